// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Central pipeline sequencer for the 5-stage core. Each cycle it
//             combines the EX redirect, the ID load-use hazard and data-memory
//             wait states into one consistent set of stall, flush and redirect
//             controls. Memory waits are tracked by a timeout FSM. Saturating
//             counters record stall cycles and redirect cycles.
//  Ports    : clk, reset (async, active-high)
//             id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID source operands
//             ex_rd/ex_mem_read/ex_redirect/ex_target : EX-stage status
//             mem_req/dmem_ready                      : MEM-stage handshake
//             pc_stall, if_id_stall/flush, id_ex_stall/flush, ex_mem_stall,
//             pc_redirect/pc_target                   : pipeline controls
//             mem_timeout                             : sticky wait error
//             stall_cycles, redirect_cnt              : perf counters
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_target,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  logic load_use;
  logic mem_wait;
  logic freeze;
  logic run_eval;

  // A load to x0 never produces a value, so it cannot create a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mem_wait = mem_req && !dmem_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        // The cycle that first sees the wait already counts as one.
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // Once a wait has begun only dmem_ready ends it, even if mem_req drops.
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_TIMEOUT: begin
        state_d = ST_TIMEOUT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    redirect_cnt_d = redirect_cnt_q;
    if (pc_redirect && (redirect_cnt_q != CNT_MAX)) begin
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (Mealy: acts on the same edge as the inputs that cause it)
  // --------------------------------------------------------------------------
  always_comb begin
    freeze       = 1'b0;
    run_eval     = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;

    // State is already RUN while reset is high, but RUN still decodes inputs,
    // so the controls are masked explicitly.
    if (!reset) begin
      case (state_q)
        ST_RUN:      begin freeze = mem_wait;    run_eval = !mem_wait;  end
        ST_MEM_WAIT: begin freeze = !dmem_ready; run_eval = dmem_ready; end
        ST_TIMEOUT:  begin freeze = 1'b1;                               end
        default:     begin freeze = 1'b0;                               end
      endcase
    end

    if (freeze) begin
      // EX is held too, so a pending redirect is re-presented after release.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (run_eval) begin
      if (ex_redirect) begin
        // The ID instruction is squashed, so its load-use hazard is moot.
        pc_redirect = 1'b1;
        pc_target   = ex_target;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // One bubble suffices: the bubble in EX has ex_mem_read=0 next cycle.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign mem_timeout  = (state_q == ST_TIMEOUT);
  assign stall_cycles = stall_cycles_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl. A cycle-level reference
//             model counts consecutive memory-wait cycles and applies the
//             priority rules directly; a negedge process compares every cycle.
//             Directed literal checks pin the key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int XLEN         = 32;
  localparam int WAIT_TIMEOUT = 16;
  localparam int CNT_W        = 4;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic             mem_req, dmem_ready;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic             id_ex_flush, ex_mem_stall, pc_redirect, mem_timeout;
  logic [XLEN-1:0]  pc_target;
  logic [CNT_W-1:0] stall_cycles, redirect_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.XLEN(XLEN), .WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_dead;     // timed out; only reset clears
  bit m_waiting;  // inside a memory-wait episode
  int m_nr;       // consecutive frozen-by-memory cycles so far
  int m_stall;
  int m_redir;

  function automatic bit m_frozen();
    if (m_dead) return 1'b1;
    if (m_waiting) return !dmem_ready;
    return mem_req && !dmem_ready;
  endfunction

  // {pc_stall,if_id_stall,if_id_flush,id_ex_stall,id_ex_flush,ex_mem_stall,pc_redirect,mem_timeout}
  function automatic logic [7:0] m_ctrl();
    bit lu;
    if (reset) return 8'h00;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (m_frozen())  return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_dead};
    if (ex_redirect) return 8'b0010_1010;
    if (lu)          return 8'b1100_1000;
    return 8'h00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dead <= 0; m_waiting <= 0; m_nr <= 0; m_stall <= 0; m_redir <= 0;
    end else begin
      if (m_ctrl() & 8'h80 && m_stall < CMAX) m_stall <= m_stall + 1;
      if (m_ctrl() & 8'h02 && m_redir < CMAX) m_redir <= m_redir + 1;
      if (!m_dead) begin
        if (m_frozen()) begin
          m_waiting <= 1;
          m_nr      <= m_nr + 1;
          if (m_nr + 1 >= WAIT_TIMEOUT) m_dead <= 1;
        end else begin
          m_waiting <= 0;
          m_nr      <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    e = m_ctrl();
    check("ctrl", {24'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, pc_redirect, mem_timeout}, {24'd0, e});
    check("pc_target", pc_target, e[1] ? ex_target : 32'd0);
    check("stall_cycles", {28'd0, stall_cycles}, m_stall);
    check("redirect_cnt", {28'd0, redirect_cnt}, m_redir);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_redirect = 0; ex_target = 0;
    mem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) tick();
    reset = 0;
    tick();
    #2 check("reset_stall_cycles", {28'd0, stall_cycles}, 0);
    check("reset_pc_stall", {31'd0, pc_stall}, 0);

    // T1: load-use on rs1
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #2 check("t1_pc_stall", {31'd0, pc_stall}, 1);
    check("t1_if_id_stall", {31'd0, if_id_stall}, 1);
    check("t1_id_ex_flush", {31'd0, id_ex_flush}, 1);
    tick();
    ex_mem_read = 0;
    #2 check("t1_bubble_clear", {31'd0, pc_stall}, 0);
    check("t1_stall_cycles", {28'd0, stall_cycles}, 1);

    // load-use on rs2, then same regs with the uses bit clear
    tick();
    idle(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 5; id_rs2 = 7; id_uses_rs2 = 1;
    #2 check("rs2_pc_stall", {31'd0, pc_stall}, 1);
    tick();
    id_uses_rs2 = 0;
    #2 check("rs2_unused", {31'd0, pc_stall}, 0);

    // T2: load to x0
    tick();
    idle(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #2 check("t2_ctrl", {24'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                         id_ex_flush, ex_mem_stall, pc_redirect, mem_timeout}, 0);

    // T3: redirect beats load-use
    tick();
    ex_rd = 5; id_rs1 = 5; ex_redirect = 1; ex_target = 32'h100;
    #2 check("t3_pc_redirect", {31'd0, pc_redirect}, 1);
    check("t3_pc_target", pc_target, 32'h100);
    check("t3_pc_stall", {31'd0, pc_stall}, 0);
    check("t3_flushes", {30'd0, if_id_flush, id_ex_flush}, 3);
    tick();
    idle();
    #2 check("t3_redirect_cnt", {28'd0, redirect_cnt}, 1);

    // T4: memory wait holds a pending redirect for 3 cycles
    tick();
    mem_req = 1; dmem_ready = 0; ex_redirect = 1; ex_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #2 check("t4_no_redirect", {31'd0, pc_redirect}, 0);
      check("t4_ex_mem_stall", {31'd0, ex_mem_stall}, 1);
      tick();
    end
    dmem_ready = 1;
    #2 check("t4_release_redirect", {31'd0, pc_redirect}, 1);
    check("t4_release_target", pc_target, 32'h200);
    check("t4_release_stall", {31'd0, ex_mem_stall}, 0);
    tick();
    idle();
    #2 check("t4_redirect_cnt", {28'd0, redirect_cnt}, 2);

    // 15 not-ready cycles is one short of the timeout; counter saturates
    tick();
    mem_req = 1; dmem_ready = 0;
    repeat (15) tick();
    mem_req = 0; dmem_ready = 1;
    #2 check("b15_no_timeout", {31'd0, mem_timeout}, 0);
    check("b15_released", {31'd0, pc_stall}, 0);
    check("b15_saturated", {28'd0, stall_cycles}, CMAX);

    // T5: 16 not-ready cycles reach TIMEOUT
    tick();
    mem_req = 1; dmem_ready = 0;
    repeat (16) tick();
    dmem_ready = 1; mem_req = 0; ex_redirect = 1; ex_target = 32'h300;
    #2 check("t5_mem_timeout", {31'd0, mem_timeout}, 1);
    check("t5_frozen", {31'd0, pc_stall}, 1);
    check("t5_no_redirect", {31'd0, pc_redirect}, 0);
    tick();
    #2 check("t5_still_frozen", {31'd0, ex_mem_stall}, 1);

    // T6: asynchronous reset out of TIMEOUT
    reset = 1;
    #1 check("t6_mem_timeout", {31'd0, mem_timeout}, 0);
    check("t6_stall_cycles", {28'd0, stall_cycles}, 0);
    check("t6_redirect_cnt", {28'd0, redirect_cnt}, 0);
    check("t6_pc_stall", {31'd0, pc_stall}, 0);
    tick();
    reset = 0;
    idle();
    tick();
    ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
    #2 check("t6_run_load_use", {31'd0, pc_stall}, 1);
    check("t6_run_no_freeze", {31'd0, ex_mem_stall}, 0);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
